// File: rtl/tcam_host_if.sv
// Host-side command/response initiator for a 16-entry ternary CAM.
// Define WRITE_ACK_EN to have writes return an acknowledge response.
module tcam_host_if #(
  parameter int DW         = 16,
  parameter int AW         = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SEARCH_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_value,
  input  logic [DW-1:0] cmd_care,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_op,
  output logic          rsp_found,
  output logic [AW-1:0] rsp_addr,
  output logic [DW-1:0] rsp_value,
  output logic [DW-1:0] rsp_care,
  output logic          t_we,
  output logic [AW-1:0] t_waddr,
  output logic [DW-1:0] t_value,
  output logic [DW-1:0] t_care,
  output logic          t_search,
  input  logic          t_found,
  input  logic [AW-1:0] t_saddr,
  input  logic [DW-1:0] t_svalue,
  input  logic [DW-1:0] t_scare,
  output logic          busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + AW + 2 * DW;
  localparam int CW = $clog2(SEARCH_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    SEARCH,
    RESP
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW:0]   wp;
  logic [PW:0]   rp;
  logic [EW-1:0] head;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          last;
  logic          cap;
  logic          wdone;
  logic          ack;

  assign empty = (wp == rp);
  assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign cmd_ready = !rst && !full;
  assign push  = cmd_valid && cmd_ready;
  assign head  = mem[rp[PW-1:0]];
  assign last  = (cnt == CW'(SEARCH_LAT - 1));
  assign busy  = !empty || (state != IDLE);

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    cap     = 1'b0;
    wdone   = 1'b0;
    ack     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = head[EW-1] ? SEARCH : WRITE;
        end
      end
      WRITE: begin
        wdone = 1'b1;
`ifdef WRITE_ACK_EN
        state_d = RESP;
`else
        state_d = IDLE;
`endif
      end
      SEARCH: begin
        if (last) begin
          cap     = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          ack     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // a push into a full FIFO is refused even when a pop happens alongside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[PW-1:0]] <= {cmd_op, cmd_addr, cmd_value, cmd_care};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_we      <= 1'b0;
      t_search  <= 1'b0;
      t_waddr   <= '0;
      t_value   <= '0;
      t_care    <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_op    <= 1'b0;
      rsp_found <= 1'b0;
      rsp_addr  <= '0;
      rsp_value <= '0;
      rsp_care  <= '0;
    end else begin
      if (pop) begin
        t_we     <= !head[EW-1];
        t_search <= head[EW-1];
        t_waddr  <= head[EW-2 -: AW];
        t_value  <= head[2*DW-1 -: DW];
        t_care   <= head[DW-1:0];
        cnt      <= '0;
      end else begin
        if (wdone) t_we <= 1'b0;
        if (state == SEARCH) begin
          if (last) t_search <= 1'b0;
          else      cnt <= cnt + CW'(1);
        end
      end
      // a miss returns zeroed fields, not whatever the TCAM drives
      if (cap) begin
        rsp_valid <= 1'b1;
        rsp_op    <= 1'b1;
        rsp_found <= t_found;
        rsp_addr  <= t_found ? t_saddr : '0;
        rsp_value <= t_found ? t_svalue : '0;
        rsp_care  <= t_found ? t_scare : '0;
      end
`ifdef WRITE_ACK_EN
      if (wdone) begin
        rsp_valid <= 1'b1;
        rsp_op    <= 1'b0;
        rsp_found <= 1'b0;
        rsp_addr  <= t_waddr;
        rsp_value <= t_value;
        rsp_care  <= t_care;
      end
`endif
      if (ack) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tcam_host_if.sv
// Directed self-checking bench for tcam_host_if with a behavioural TCAM.
// Honours WRITE_ACK_EN when the design is built with it.
module tb_tcam_host_if;

  localparam int SL = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [3:0]  cmd_addr;
  logic [15:0] cmd_value;
  logic [15:0] cmd_care;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_op;
  logic        rsp_found;
  logic [3:0]  rsp_addr;
  logic [15:0] rsp_value;
  logic [15:0] rsp_care;
  logic        t_we;
  logic [3:0]  t_waddr;
  logic [15:0] t_value;
  logic [15:0] t_care;
  logic        t_search;
  logic        t_found;
  logic [3:0]  t_saddr;
  logic [15:0] t_svalue;
  logic [15:0] t_scare;
  logic        busy;

  typedef struct packed {
    logic        op;
    logic        found;
    logic [3:0]  addr;
    logic [15:0] value;
    logic [15:0] care;
  } rsp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   overlap = 0;
  int   we_dbl  = 0;
  int   srch_cyc = 0;
  logic prev_we = 1'b0;
  rsp_t rq[$];
  logic [3:0] wq[$];

  logic [15:0] mv [16];
  logic [15:0] mc [16];
  logic [15:0] mvld = '0;

  tcam_host_if #(
    .DW(16), .AW(4), .FIFO_DEPTH(4), .SEARCH_LAT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_value(cmd_value), .cmd_care(cmd_care),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_op(rsp_op), .rsp_found(rsp_found),
    .rsp_addr(rsp_addr), .rsp_value(rsp_value),
    .rsp_care(rsp_care),
    .t_we(t_we), .t_waddr(t_waddr),
    .t_value(t_value), .t_care(t_care),
    .t_search(t_search), .t_found(t_found),
    .t_saddr(t_saddr), .t_svalue(t_svalue),
    .t_scare(t_scare), .busy(busy)
  );

  always #5 clk = ~clk;

  // TCAM model: lowest matching address wins; a miss drives junk fields
  always_comb begin
    t_found  = 1'b0;
    t_saddr  = 4'hF;
    t_svalue = 16'hDEAD;
    t_scare  = 16'hBEEF;
    for (int i = 15; i >= 0; i--) begin
      if (mvld[i] && (((mv[i] ^ t_value) & mc[i] & t_care) == 16'h0)) begin
        t_found  = 1'b1;
        t_saddr  = i[3:0];
        t_svalue = mv[i];
        t_scare  = mc[i];
      end
    end
  end

  always @(posedge clk) begin
    if (t_we) begin
      mv[t_waddr]   <= t_value;
      mc[t_waddr]   <= t_care;
      mvld[t_waddr] <= 1'b1;
      wq.push_back(t_waddr);
    end
    if (t_we && t_search) overlap++;
    if (t_we && prev_we) we_dbl++;
    prev_we = t_we;
    if (t_search) srch_cyc++;
    if (!rst && rsp_valid && rsp_ready)
      rq.push_back({rsp_op, rsp_found, rsp_addr, rsp_value, rsp_care});
  end

  task automatic push(input logic op, input logic [3:0] a,
                      input logic [15:0] v, input logic [15:0] c);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_value = v;
    cmd_care  = c;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout cmd_ready stuck at %b, need 1", cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout busy stuck at %b, need 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 1'b0;
    cmd_addr = '0;
    cmd_value = '0;
    cmd_care = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({t_we, t_search, rsp_valid, busy, rsp_op, rsp_found, rsp_addr,
         rsp_value, rsp_care, t_waddr, t_value, t_care} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got nonzero outputs, need all 0");
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({cmd_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release ready/busy got %b%b, need 10",
               cmd_ready, busy);
    end
  endtask

  task automatic test_write_hit();
    push(1'b0, 4'd0, 16'h0555, 16'hFF7F);
    n_tests++;
    if (t_we !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_early t_we got %b, need 0", t_we);
    end
    @(negedge clk);
    n_tests++;
    if ({t_we, t_search, t_waddr, t_value, t_care} !==
        {1'b1, 1'b0, 4'd0, 16'h0555, 16'hFF7F}) begin
      n_fail++;
      $display("FAIL wr_strobe got we=%b s=%b a=%h v=%h c=%h, need 1 0 0 0555 ff7f",
               t_we, t_search, t_waddr, t_value, t_care);
    end
    @(negedge clk);
    n_tests++;
    if (t_we !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_one_cycle t_we got %b, need 0", t_we);
    end
    wait_idle();
    rq.delete();
    push(1'b1, 4'd0, 16'h0551, 16'hFFF3);
    @(negedge clk);
    n_tests++;
    if ({t_search, t_we, rsp_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL hit_strobe search/we/rsp got %b%b%b, need 100",
               t_search, t_we, rsp_valid);
    end
    repeat (SL) @(negedge clk);
    n_tests++;
    if ({rsp_valid, rsp_op, rsp_found, rsp_addr, rsp_value, rsp_care} !==
        {1'b1, 1'b1, 1'b1, 4'd0, 16'h0555, 16'hFF7F}) begin
      n_fail++;
      $display("FAIL hit_rsp got v=%b op=%b f=%b a=%h val=%h c=%h, need 1 1 1 0 0555 ff7f",
               rsp_valid, rsp_op, rsp_found, rsp_addr, rsp_value, rsp_care);
    end
    n_tests++;
    if (t_search !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_search_len t_search got %b, need 0", t_search);
    end
    wait_idle();
  endtask

  task automatic test_miss();
    push(1'b1, 4'd0, 16'h3DFD, 16'hFFFF);
    repeat (SL + 1) @(negedge clk);
    n_tests++;
    if ({rsp_valid, rsp_op, rsp_found, rsp_addr, rsp_value, rsp_care} !==
        {1'b1, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL miss_rsp got v=%b op=%b f=%b a=%h val=%h c=%h, need 1 1 0 0 0 0",
               rsp_valid, rsp_op, rsp_found, rsp_addr, rsp_value, rsp_care);
    end
    wait_idle();
  endtask

  task automatic test_write_order();
    int exp_n;
    rq.delete();
    wq.delete();
    overlap = 0;
    we_dbl = 0;
    push(1'b0, 4'd4, 16'h1234, 16'hFFFF);
    push(1'b0, 4'd13, 16'hABCD, 16'hFFFF);
    push(1'b1, 4'd0, 16'hABCD, 16'hFFFF);
    wait_idle();
    n_tests++;
    if (wq.size() !== 2) begin
      n_fail++;
      $display("FAIL order_we_count got %0d, need 2", wq.size());
    end else begin
      n_tests++;
      if ({wq[0], wq[1]} !== {4'd4, 4'd13}) begin
        n_fail++;
        $display("FAIL order_we_addr got %0d,%0d, need 4,13", wq[0], wq[1]);
      end
    end
    n_tests++;
    if ({overlap, we_dbl} !== {32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL order_overlap got ovl=%0d dbl=%0d, need 0 0",
               overlap, we_dbl);
    end
`ifdef WRITE_ACK_EN
    exp_n = 3;
`else
    exp_n = 1;
`endif
    n_tests++;
    if (rq.size() !== exp_n) begin
      n_fail++;
      $display("FAIL order_rsp_count got %0d, need %0d", rq.size(), exp_n);
    end else begin
      n_tests++;
      if (rq[exp_n-1] !== {1'b1, 1'b1, 4'd13, 16'hABCD, 16'hFFFF}) begin
        n_fail++;
        $display("FAIL order_raw got %h, need %h", rq[exp_n-1],
                 {1'b1, 1'b1, 4'd13, 16'hABCD, 16'hFFFF});
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_t exp[5];
    logic [15:0] kv[5];
    logic [15:0] kc[5];
    kv = '{16'h0555, 16'h1234, 16'hABCD, 16'h3DFD, 16'h1234};
    kc = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
    exp[0] = {1'b1, 1'b1, 4'd0, 16'h0555, 16'hFF7F};
    exp[1] = {1'b1, 1'b1, 4'd4, 16'h1234, 16'hFFFF};
    exp[2] = {1'b1, 1'b1, 4'd13, 16'hABCD, 16'hFFFF};
    exp[3] = {1'b1, 1'b0, 4'd0, 16'h0, 16'h0};
    exp[4] = {1'b1, 1'b1, 4'd0, 16'h0555, 16'hFF7F};
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(1'b1, 4'd0, kv[i], kc[i]);
    cmd_valid = 1'b1;
    cmd_op = 1'b1;
    cmd_value = 16'h0555;
    cmd_care = 16'hFFFF;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({cmd_ready, busy, rsp_valid, rsp_addr, rsp_value} !==
        {1'b0, 1'b1, 1'b1, 4'd0, 16'h0555}) begin
      n_fail++;
      $display("FAIL bp_full got rdy=%b busy=%b v=%b a=%h val=%h, need 0 1 1 0 0555",
               cmd_ready, busy, rsp_valid, rsp_addr, rsp_value);
    end
    cmd_valid = 1'b0;
    rq.delete();
    rsp_ready = 1'b1;
    wait_idle();
    n_tests++;
    if (rq.size() !== 5) begin
      n_fail++;
      $display("FAIL bp_count got %0d, need 5", rq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (rq[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL bp_rsp%0d got %h, need %h", i, rq[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_search();
    int s0;
    int r0;
    rsp_ready = 1'b1;
    push(1'b1, 4'd0, 16'h1234, 16'hFFFF);
    push(1'b1, 4'd0, 16'hABCD, 16'hFFFF);
    n_tests++;
    if (t_search !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre t_search got %b, need 1", t_search);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({t_we, t_search, rsp_valid, busy, rsp_op, rsp_found, rsp_addr,
         rsp_value, rsp_care, t_waddr, t_value, t_care} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs got nonzero, need all 0 (srch=%b busy=%b)",
               t_search, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    s0 = srch_cyc;
    r0 = rq.size();
    repeat (10) @(negedge clk);
    n_tests++;
    if ({cmd_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_mid_release ready/busy got %b%b, need 10",
               cmd_ready, busy);
    end
    n_tests++;
    if ((srch_cyc - s0) !== 0 || (rq.size() - r0) !== 0) begin
      n_fail++;
      $display("FAIL rst_stale got %0d search cycles %0d rsps, need 0 0",
               srch_cyc - s0, rq.size() - r0);
    end
  endtask

  task automatic test_write_ack();
    rq.delete();
`ifdef WRITE_ACK_EN
    rsp_ready = 1'b0;
    push(1'b0, 4'd10, 16'h3575, 16'hFFFF);
    repeat (2) @(negedge clk);
    n_tests++;
    if ({rsp_valid, rsp_op, rsp_found, rsp_addr, rsp_value} !==
        {1'b1, 1'b0, 1'b0, 4'd10, 16'h3575}) begin
      n_fail++;
      $display("FAIL ack_rsp got v=%b op=%b f=%b a=%h val=%h, need 1 0 0 a 3575",
               rsp_valid, rsp_op, rsp_found, rsp_addr, rsp_value);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if ({rsp_valid, rsp_addr, rsp_value} !== {1'b1, 4'd10, 16'h3575}) begin
      n_fail++;
      $display("FAIL ack_hold got v=%b a=%h val=%h, need 1 a 3575",
               rsp_valid, rsp_addr, rsp_value);
    end
    rsp_ready = 1'b1;
    wait_idle();
    n_tests++;
    if (rq.size() !== 1) begin
      n_fail++;
      $display("FAIL ack_count got %0d, need 1", rq.size());
    end
`else
    rsp_ready = 1'b1;
    push(1'b0, 4'd10, 16'h3575, 16'hFFFF);
    wait_idle();
    repeat (3) @(negedge clk);
    n_tests++;
    if (rq.size() !== 0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL noack got %0d rsps valid=%b, need 0 0", rq.size(), rsp_valid);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_hit();
    test_miss();
    test_write_order();
    test_backpressure();
    test_reset_mid_search();
    test_write_ack();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
